// File: rtl/md_unit_sched.sv
// md_unit_sched: multi-cycle HI/LO multiply/divide unit and its sequencer.
//
// Owns the architectural HI/LO registers. A mult(u)/div(u) issued from EX
// computes its full 64-bit result at the issue edge into a pending register,
// then counts down a fixed latency before committing it to HI/LO. Any later
// HI/LO-touching instruction presented while an operation is in flight gets
// a combinational stall request.
//
// Parameters:
//   MUL_LAT  cycles from mult/multu issue to HI/LO commit (1..15)
//   DIV_LAT  cycles from div/divu issue to HI/LO commit (1..15)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset     synchronous active-low reset
//   md_valid  EX holds a valid, unflushed instruction
//   md_func   0 none, 1 mthi, 2 mtlo, 3 mult(u), 4 div(u), 5-7 reserved
//   md_sign   1 signed, 0 unsigned
//   hi_rd     EX instruction is mfhi
//   lo_rd     EX instruction is mflo
//   rs_val    rs operand (dividend / multiplicand / mthi/mtlo data)
//   rt_val    rt operand (divisor / multiplier)
//   busy      a mult/div is in flight
//   md_stall  stall request toward the stall detector
//   hi, lo    architectural HI / LO
module md_unit_sched #(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic        hi_rd,
    input  logic        lo_rd,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    localparam logic [2:0] FuncMthi = 3'd1;
    localparam logic [2:0] FuncMtlo = 3'd2;
    localparam logic [2:0] FuncMult = 3'd3;
    localparam logic [2:0] FuncDiv  = 3'd4;

    localparam logic [3:0] MulLatC = 4'(MUL_LAT);
    localparam logic [3:0] DivLatC = 4'(DIV_LAT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Multiply: sign-extend (signed) or zero-extend (unsigned) to 64 bits; the low
    // 64 bits of the product are then correct for both interpretations.
    logic [63:0] mul_a, mul_b, mul_p;

    assign mul_a = {{32{md_sign & rs_val[31]}}, rs_val};
    assign mul_b = {{32{md_sign & rt_val[31]}}, rt_val};
    assign mul_p = mul_a * mul_b;

    // Divide: unsigned divide of magnitudes, then restore signs. The quotient is
    // negative when operand signs differ; the remainder follows the dividend.
    // 0x8000_0000 / -1 falls out naturally as 0x8000_0000 rem 0.
    logic        rs_neg, rt_neg;
    logic [31:0] abs_rs, abs_rt;
    logic [31:0] div_q_u, div_r_u, div_q, div_r;
    logic [63:0] div_res;

    assign rs_neg  = md_sign & rs_val[31];
    assign rt_neg  = md_sign & rt_val[31];
    assign abs_rs  = rs_neg ? -rs_val : rs_val;
    assign abs_rt  = rt_neg ? -rt_val : rt_val;
    assign div_q_u = abs_rs / abs_rt;
    assign div_r_u = abs_rs % abs_rt;
    assign div_q   = (rs_neg ^ rt_neg) ? -div_q_u : div_q_u;
    assign div_r   = rs_neg ? -div_r_u : div_r_u;
    // Divide by zero: quotient all ones, remainder is the dividend.
    assign div_res = (rt_val == 32'd0) ? {rs_val, 32'hFFFF_FFFF} : {div_r, div_q};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (md_valid) begin
                    case (md_func)
                        FuncMthi: hi_d = rs_val;
                        FuncMtlo: lo_d = rs_val;
                        FuncMult: begin
                            state_d = StMul;
                            cnt_d   = MulLatC;
                            pend_d  = mul_p;
                        end
                        FuncDiv: begin
                            state_d = StDiv;
                            cnt_d   = DivLatC;
                            pend_d  = div_res;
                        end
                        default: ;
                    endcase
                end
            end
            StMul, StDiv: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    {hi_d, lo_d} = pend_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    logic req;

    always_comb begin
        req      = md_valid && ((md_func >= FuncMthi && md_func <= FuncDiv) || hi_rd || lo_rd);
        busy     = (state_q != StIdle);
        md_stall = req && busy;
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: doc/md_unit_sched.md
Name: md_unit_sched

Overview:
Multi-cycle HI/LO multiply/divide unit and its sequencer. It sits beside the EX-stage ALU and is driven by the decoded MDFunc/MDSign/MDHIWB/MDLOWB control fields. It owns the HI and LO registers and sequences mult/multu/div/divu over a fixed latency. It raises a stall request toward the stall detector whenever a later HI/LO-touching instruction reaches EX while an operation is still in flight.

Parameters:
MUL_LAT, 5, cycles from mult/multu issue to HI/LO commit (legal range 1..15)
DIV_LAT, 10, cycles from div/divu issue to HI/LO commit (legal range 1..15)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
md_valid  in  1  EX holds a valid, unflushed instruction this cycle
md_func  in  3  0 none, 1 mthi, 2 mtlo, 3 mult(u), 4 div(u), 5-7 reserved
md_sign  in  1  1 = signed (mult/div), 0 = unsigned (multu/divu)
hi_rd  in  1  EX instruction is mfhi
lo_rd  in  1  EX instruction is mflo
rs_val  in  32  forwarded rs operand (dividend / multiplicand / mthi/mtlo data)
rt_val  in  32  forwarded rt operand (divisor / multiplier)
busy  out  1  a mult/div is in flight
md_stall  out  1  stall request to the stall detector
hi  out  32  architectural HI
lo  out  32  architectural LO

Behaviour:
- Sampling and polarity:
  - All inputs are sampled on the rising edge of clk.
  - reset is synchronous and active-low.
  - reset==0 at an edge: state=IDLE, counter=0, hi=0, lo=0, pending result=0. busy=0 and md_stall=0 in the following cycle.
  - Reset asserted mid-operation aborts the operation silently; the result is never committed.
- States: IDLE, MUL, DIV. busy = (state != IDLE).
- Stall rule:
  - req = md_valid && (md_func in 1..4 || hi_rd || lo_rd).
  - md_stall = req && busy. This is combinational, with no register stage.
- Issue:
  - Issue happens in cycle T when state==IDLE, md_valid==1 and md_func is 3 or 4.
  - At the edge ending T, the full 64-bit result is computed from rs_val/rt_val and latched into a pending register.
  - The counter loads MUL_LAT or DIV_LAT, and the state moves to MUL or DIV.
- Countdown:
  - In MUL/DIV the counter decrements every cycle.
  - At the edge of the cycle where counter==1, the pending result is written to hi/lo and the state returns to IDLE.
  - busy is high for cycles T+1..T+LAT. New hi/lo are visible from T+LAT+1.
  - mfhi/mflo in EX at T+LAT is stalled; the same instruction at T+LAT+1 proceeds and reads the new value.
- Stall during countdown: requests are ignored while busy. The pipeline holds the requester in EX, and it re-presents the request once state==IDLE.
- Multiply: hi:lo = 64-bit product.
  - Signed: two's-complement product of the sign-interpreted operands.
  - Unsigned: zero-extended product.
- Divide: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend when signed.
  - Divisor == 0 (signed or unsigned): lo=32'hFFFF_FFFF, hi=rs_val.
  - Signed 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- mthi/mtlo: when state==IDLE and md_valid, at the same edge hi<=rs_val (func 1) or lo<=rs_val (func 2). Single cycle; busy stays 0.
- Reserved func 5-7 and md_valid==0: no effect on state, hi or lo.
- No cancel path: once issued, an operation always commits unless reset intervenes. Flush of the issuing instruction after issue does not abort it.
- hi/lo change only at commit, mthi/mtlo, or reset.

Test Plan:
- Reset mid-op: issue div, pull reset low 3 cycles later -> next cycle busy=0, hi=lo=0, and no commit occurs DIV_LAT cycles after the issue.
- Signed mult: mult rs=32'hFFFF_FFFE (-2), rt=3, then mflo in the next EX cycle -> md_stall=1 for exactly MUL_LAT cycles; commit gives hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA; busy falls after MUL_LAT cycles.
- Unsigned mult: multu rs=32'hFFFF_FFFF, rt=32'hFFFF_FFFF -> after MUL_LAT cycles hi=32'hFFFF_FFFE, lo=1.
- Signed and unsigned divide: div rs=-7, rt=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. divu rs=7, rt=0 -> lo=32'hFFFF_FFFF, hi=7. div 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- Back-to-back mult/div: mult held in EX while div is busy -> md_stall=1 throughout; mult issues in the first IDLE cycle; final hi/lo hold the mult result; md_valid=0 cycles cause no writes.
- mthi/mtlo and reserved func: mthi rs=32'h1234_5678 followed immediately by mfhi -> hi=32'h1234_5678 next cycle, md_stall never asserted. mtlo while busy -> stalled, lo unchanged until it is re-presented after commit. md_func=6 -> no change.
